// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, FSM states and error codes for the maze router blocks
package maze_pkg;
  localparam int GRID_N = 64;
  localparam int GRID_W = 8;
  localparam logic [7:0] TERM_BASE = 8'h80;
  localparam logic [7:0] ROUTED = 8'h00;
  localparam logic [7:0] BLOCKED = 8'hFF;
  localparam logic [2:0] ERR_OK = 3'd0;
  localparam logic [2:0] ERR_FEW = 3'd1;
  localparam logic [2:0] ERR_IDX = 3'd2;
  localparam logic [2:0] ERR_UNROUTED = 3'd3;
  localparam logic [2:0] ERR_DISCONN = 3'd4;
  localparam logic [2:0] ERR_STRAY = 3'd5;
  typedef enum logic [2:0] {IDLE, RD_GRID, RD_TERM, FLOOD, EVAL, DONE} state_t;
endpackage

// File: rtl/maze_flood_step.sv
// maze_flood_step: one-step 4-neighbour expansion of a reach set over routed cells
module maze_flood_step
  import maze_pkg::*;
(
  input  logic [GRID_N-1:0] reach,
  input  logic [GRID_N-1:0] routed,
  output logic [GRID_N-1:0] reach_nxt
);
  localparam logic [GRID_N-1:0] COL0 = 64'h0101_0101_0101_0101;
  localparam logic [GRID_N-1:0] COL7 = 64'h8080_8080_8080_8080;
  logic [GRID_N-1:0] nbr;
  // east/west moves must not wrap into the adjacent row
  assign nbr = ((reach << 1) & ~COL0) | ((reach >> 1) & ~COL7) |
               (reach << GRID_W) | (reach >> GRID_W);
  assign reach_nxt = reach | (nbr & routed);
endmodule

// File: rtl/maze_route_checker.sv
// maze_route_checker: reads the routed grid and terminals from SRAM and verifies
// that all terminals are connected with no stray routed cells.
module maze_route_checker
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] term_count,
  input  logic [7:0] data_in,
  output logic       cs,
  output logic       we,
  output logic [7:0] address,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_code,
  output logic [6:0] wirelength
);
  state_t state_q, state_d;
  logic [7:0] address_q, address_d, prv_addr_q, prv_addr_d;
  logic cs_q, cs_d, prv_vld_q, prv_vld_d, pass_q, pass_d;
  logic [6:0] tc_q, tc_d, wl_q, wl_d;
  logic [2:0] err_q, err_d, eval_err;
  logic [GRID_N-1:0] routed_q, routed_d, term_mask_q, term_mask_d, reach_q, reach_d, reach_nxt;

  maze_flood_step u_step (.reach(reach_q), .routed(routed_q), .reach_nxt(reach_nxt));

  assign eval_err = err_q != ERR_OK ? err_q :
                    |(term_mask_q & ~reach_q) ? ERR_DISCONN :
                    |(routed_q & ~reach_q) ? ERR_STRAY : ERR_OK;

  always_comb begin
    state_d = state_q;
    address_d = address_q;
    cs_d = cs_q;
    tc_d = tc_q;
    wl_d = wl_q;
    err_d = err_q;
    pass_d = pass_q;
    routed_d = routed_q;
    term_mask_d = term_mask_q;
    reach_d = reach_q;
    prv_vld_d = cs_q;
    prv_addr_d = address_q;
    // read data always belongs to the address issued in the previous cycle
    if (prv_vld_q) begin
      if (!prv_addr_q[7]) begin
        routed_d[prv_addr_q[5:0]] = data_in == ROUTED;
        wl_d = wl_q + {6'd0, data_in == ROUTED};
      end else if (data_in >= 8'(GRID_N)) begin
        if (err_q == ERR_OK) err_d = ERR_IDX;
      end else begin
        term_mask_d[data_in[5:0]] = 1'b1;
        if (!routed_q[data_in[5:0]] && err_q == ERR_OK) err_d = ERR_UNROUTED;
        if (prv_addr_q[6:0] == 7'd0) reach_d[data_in[5:0]] = 1'b1;
      end
    end
    case (state_q)
      IDLE, DONE:
        if (start) begin
          pass_d = 1'b0;
          wl_d = 7'd0;
          routed_d = '0;
          term_mask_d = '0;
          reach_d = '0;
          tc_d = term_count;
          err_d = term_count < 7'd2 ? ERR_FEW : ERR_OK;
          state_d = term_count < 7'd2 ? DONE : RD_GRID;
          cs_d = term_count >= 7'd2;
          address_d = 8'h00;
        end
      RD_GRID: begin
        address_d = address_q == 8'(GRID_N - 1) ? TERM_BASE : address_q + 8'd1;
        state_d = address_q == 8'(GRID_N - 1) ? RD_TERM : RD_GRID;
      end
      RD_TERM:
        if (cs_q) begin
          cs_d = address_q[6:0] != tc_q - 7'd1;
          address_d = cs_d ? address_q + 8'd1 : address_q;
        end else begin
          state_d = FLOOD;
        end
      FLOOD:
        if (err_q != ERR_OK || reach_nxt == reach_q) state_d = EVAL;
        else reach_d = reach_nxt;
      EVAL: begin
        err_d = eval_err;
        pass_d = eval_err == ERR_OK;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      address_q <= 8'h00;
      prv_addr_q <= 8'h00;
      cs_q <= 1'b0;
      prv_vld_q <= 1'b0;
      tc_q <= 7'd0;
      wl_q <= 7'd0;
      err_q <= ERR_OK;
      pass_q <= 1'b0;
      routed_q <= '0;
      term_mask_q <= '0;
      reach_q <= '0;
    end else begin
      state_q <= state_d;
      address_q <= address_d;
      prv_addr_q <= prv_addr_d;
      cs_q <= cs_d;
      prv_vld_q <= prv_vld_d;
      tc_q <= tc_d;
      wl_q <= wl_d;
      err_q <= err_d;
      pass_q <= pass_d;
      routed_q <= routed_d;
      term_mask_q <= term_mask_d;
      reach_q <= reach_d;
    end
  end

  assign cs = cs_q;
  assign we = 1'b0;
  assign address = address_q;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign err_code = err_q;
  assign wirelength = wl_q;
endmodule

// File: tb/tb_maze_route_checker.sv
// tb_maze_route_checker: directed checks of the route checker against a behavioural SRAM
module tb_maze_route_checker;
  logic clk = 0, reset = 1, start = 0;
  logic [6:0] term_count = 0;
  logic [7:0] data_in = 0;
  logic cs, we, busy, done, pass;
  logic [7:0] address;
  logic [2:0] err_code;
  logic [6:0] wirelength;
  logic [7:0] mem [0:255];
  logic cs_seen = 0, we_seen = 0;
  int n_tests = 0, n_fail = 0;

  typedef struct {
    string tag;
    logic [2:0] err;
    logic p;
    logic [6:0] wl;
    int lat;
  } exp_t;
  exp_t sb[$];

  maze_route_checker dut (
    .clk(clk), .reset(reset), .start(start), .term_count(term_count), .data_in(data_in),
    .cs(cs), .we(we), .address(address), .busy(busy), .done(done), .pass(pass),
    .err_code(err_code), .wirelength(wirelength)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cs) data_in <= mem[address];
    if (cs) cs_seen <= 1'b1;
    if (we) we_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] g, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    for (int i = 0; i < 64; i++) mem[i] = g[i] ? 8'h00 : 8'hFF;
    mem[128] = t0;
    mem[129] = t1;
    mem[130] = t2;
  endtask

  task automatic run(input string tag, input logic [6:0] tc, input logic [2:0] err, input logic [6:0] wl, input int lat);
    exp_t e;
    int cnt;
    sb.push_back('{tag, err, err == 3'd0, wl, lat});
    @(negedge clk);
    term_count = tc;
    start = 1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 0;
      cnt++;
    end while (!done && cnt < 300);
    e = sb.pop_front();
    chk({e.tag, "_lat"}, cnt, e.lat);
    chk({e.tag, "_err"}, err_code, e.err);
    chk({e.tag, "_pass"}, pass, e.p);
    chk({e.tag, "_wl"}, wirelength, e.wl);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"}, cs, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_wl"}, wirelength, 0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 0;
    chk_reset_vals("rst");
    load(64'h7, 8'd0, 8'd2, 8'd0);
    run("path", 7'd2, 3'd0, 7'd3, 72);
    load(64'h5, 8'd0, 8'd2, 8'd0);
    run("gap", 7'd2, 3'd4, 7'd2, 70);
    load(64'h180, 8'd7, 8'd8, 8'd0);
    run("nowrap", 7'd2, 3'd4, 7'd2, 70);
    load(64'h7, 8'd0, 8'd70, 8'd0);
    run("idx", 7'd2, 3'd2, 7'd3, 70);
    load(64'h7, 8'd0, 8'd5, 8'd0);
    run("unrouted", 7'd2, 3'd3, 7'd3, 70);
    load(64'h7, 8'd0, 8'd0, 8'd2);
    run("dup", 7'd3, 3'd0, 7'd3, 73);
    load(64'h0000_0100_0001_0101, 8'd0, 8'd16, 8'd0);
    run("stray", 7'd2, 3'd5, 7'd4, 72);
    @(negedge clk);
    cs_seen = 0;
    run("few", 7'd1, 3'd1, 7'd0, 1);
    chk("few_cs", cs_seen, 0);
    load(64'h7, 8'd0, 8'd2, 8'd0);
    term_count = 7'd2;
    start = 1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 0;
      cnt++;
    end while (!(busy && address[7]) && cnt < 200);
    chk("rdterm_reached", address[7], 1);
    reset = 1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 0;
    run("after_rst", 7'd2, 3'd0, 7'd3, 72);
    chk("no_write", we_seen, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maze_route_checker.md
# maze_route_checker

Post-route checker for the 8x8 maze router. When the router signals completion, this block reads the routed grid (addresses 0x00–0x3F) and the terminal list (from 0x80) out of the shared SRAM, with `term_count` terminals. It flood-fills over routed cells (0x00) from the first terminal and reports pass/fail, an error code and the wirelength. It is a downstream consumer of the router's SRAM image and owns the SRAM port only while busy.

## Interface
- `GRID_N`, 64: grid cells, 8 columns x 8 rows, row-major.
- `TERM_BASE`, 8'h80: SRAM address of terminal[0].
- `ROUTED`, 8'h00: cell value meaning routed or terminal.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin check; sampled only in IDLE.
- `term_count` input 7: number of terminals, 0–64; sampled with `start`.
- `data_in` input 8: SRAM read data, one-cycle latency.
- `cs` output 1: SRAM chip select.
- `we` output 1: SRAM write enable; constant 0.
- `address` output 8: SRAM address, registered.
- `busy` output 1: high from the cycle after accepted `start` until DONE.
- `done` output 1: high in DONE; held until the next accepted `start` or reset.
- `pass` output 1: result valid when `done`.
- `err_code` output 3: 0 ok, 1 fewer than 2 terminals, 2 terminal index ≥64, 3 terminal cell not ROUTED, 4 terminals disconnected, 5 stray routed cell unreachable.
- `wirelength` output 7: count of ROUTED cells in the grid, 0–64.

## Operation
- States: IDLE, RD_GRID, RD_TERM, FLOOD, EVAL, DONE.
- IDLE: if `start` and `term_count < 2`, go to DONE with err 1 and no SRAM access. Otherwise go to RD_GRID with `address` = 0 and `cs` = 1.
- RD_GRID: issue addresses 0..63, one per cycle. The data returning for address k sets `routed[k]` = (`data_in` == ROUTED) and increments `wirelength` if set. After the address 63 issue, the next address is TERM_BASE and the state moves to RD_TERM.
- RD_TERM: issue TERM_BASE..TERM_BASE+term_count-1.
  - A returned value ≥64 latches err 2.
  - Otherwise its bit is set in `term_mask`. If `routed` at that index is 0, err 3 is latched.
  - Terminal[0] seeds `reach`.
  - Only the first error is latched.
  - `cs` drops after the last issue; the state moves to FLOOD once the last data has returned.
- FLOOD: `reach_nxt` = `reach` | (neighbours(`reach`) & `routed`). Neighbours are ±1 masked at column 0/7 (no row wrap) and ±8 truncated at rows 0/7. Repeat until `reach_nxt` == `reach`, at most 64 iterations. If an error is already latched, skip directly to EVAL.
- EVAL, in priority order:
  - the latched error;
  - else `term_mask` & ~`reach` ≠ 0 gives err 4;
  - else `routed` & ~`reach` ≠ 0 gives err 5;
  - else pass.
  - Then go to DONE.
- DONE: `pass` = (err == 0). Hold all results. An accepted `start` clears the results and restarts.
- Duplicate terminals are legal.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, `cs` 0, `we` 0, `address` 8'h00, `busy` 0, `done` 0, `pass` 0, `err_code` 0, `wirelength` 0.
- Start accepted in cycle t: `address` 0 is driven at t+1, and its data arrives at t+2.
- The grid takes 64 issue cycles. The terminals take `term_count` cycles, plus 1 latency cycle.
- FLOOD takes (path hops + 1) cycles, at most 65. EVAL takes 1 cycle.
- `done` rises in the cycle after EVAL.
- Reset mid-operation aborts within one cycle to reset values. No SRAM write ever occurs.

## Structure
- Shared package `maze_pkg`:
  - constants GRID_N, GRID_W = 8, TERM_BASE, ROUTED, BLOCKED = 8'hFF;
  - state enum;
  - err_code localparams.
- Sub-module `maze_flood_step`: combinational one-step 64-bit neighbour expansion (`reach`, `routed` in; `reach_nxt` out), reusable by the router.

## Test plan
- Path 0→1→2 ROUTED, rest 8'hFF, terminals {0,2}, `term_count` 2 → `pass` 1, err 0, `wirelength` 3.
- Same grid with cell 1 = 8'hFF, terminals {0,2} → err 4, `wirelength` 2.
- Cells 7 and 8 ROUTED, terminals {7,8} → err 4; checks the no-row-wrap mask.
- Terminals {0,70} → err 2. `term_count` 1 → err 1 with `cs` never asserted.
- Valid path {0,8,16} plus isolated ROUTED cell 40 → err 5, `wirelength` 4.
- Reset asserted during RD_TERM → next cycle all outputs at reset values; a new `start` completes normally.
